fifo_bit_packer: RTL and testbench
==================================

// Module: fifo_bit_packer
// PURPOSE
//  Read-side consumer of fifo_1x1: pops DATA_WIDTH-bit beats from the FIFO read port and packs
//  WORD_BEATS consecutive beats into one wide word, presented downstream on a valid/ready handshake.
//  Sits in the FIFO read clock domain; converts the serial FIFO stream into parallel words.
// PARAMETERS
//  DATA_WIDTH  1  width of one FIFO beat; must equal the FIFO's DATA_WIDTH
//  WORD_BEATS  8  beats per output word (>=2); output width OUT_W = DATA_WIDTH*WORD_BEATS
// PORTS
//  rd_clk        in   1                      single clock (FIFO read clock); all logic on rising edge
//  reset_n       in   1                      asynchronous, active-low reset
//  fifo_rd_data  in   DATA_WIDTH             FIFO read data, valid the cycle after fifo_rd_en && !fifo_empty
//  fifo_empty    in   1                      FIFO empty flag
//  fifo_rd_en    out  1                      pop request to FIFO
//  out_data      out  OUT_W                  packed word; beat 0 in bits [DATA_WIDTH-1:0] (LSB-first)
//  out_valid     out  1                      out_data holds a complete word
//  out_ready     in   1                      downstream accepts word when out_valid && out_ready
//  beat_count    out  $clog2(WORD_BEATS+1)   beats captured into current word (debug/status)
//  out_parity    out  1                      even parity of out_data (only with FIFO_PACKER_PARITY_EN)
// BEHAVIOUR
//  Reset (reset_n=0, async): fifo_rd_en=0, out_valid=0, out_data=0, beat_count=0, state=FILL,
//   issued=0, pending=0, out_parity=0. Reset mid-word discards partial beats; no pop in flight survives.
//  State FILL: fifo_rd_en = !fifo_empty && (issued < WORD_BEATS); combinational from registered state.
//   issued increments on each cycle fifo_rd_en=1. pending <= fifo_rd_en (1-cycle FIFO read latency).
//   When pending=1: fifo_rd_data is shifted into slot beat_count; beat_count++.
//   Sustained throughput: one beat per cycle while FIFO non-empty.
//  FILL -> HOLD on the cycle the WORD_BEATS-th beat is captured; out_valid=1 from the next cycle.
//  State HOLD: fifo_rd_en=0; out_data and out_valid stable until out_valid && out_ready.
//   On accept: out_valid=0, beat_count=0, issued=0, state=FILL; first new pop earliest the next cycle.
//   Word-to-word cadence with out_ready tied high and FIFO never empty: WORD_BEATS+2 cycles.
//  Empty boundary: fifo_empty=1 stalls popping only; pending beat still captured; no bubbles corrupt slots.
//  Never pops more than WORD_BEATS beats per word (issued guard); never pops while fifo_empty=1.
//  out_ready while out_valid=0 is ignored. beat_count saturates at WORD_BEATS in HOLD.
//  Latency: last beat's fifo_rd_en at cycle N -> capture at N+1 -> out_valid=1 at N+2.
// CONFIGURATION
//  FIFO_PACKER_PARITY_EN defined: out_parity port exists = ^out_data, registered with out_data,
//   valid whenever out_valid=1, 0 after reset.
//  Not defined: out_parity port and parity logic absent; all other behaviour identical.
// STRUCTURE
//  Shared header fifo_pkg.vh: state encodings ST_FILL=1'b0 / ST_HOLD=1'b1, clog2 function for
//   counter widths, common DATA_WIDTH default.
//  One sub-module: fifo_shift_packer (slot-indexed register array, load/clear controls);
//   control FSM, issued/pending counters and handshake stay in fifo_bit_packer.
// TESTING
//  1 reset_n=0 at t=2ns, released at 4ns -> all outputs 0, fifo_rd_en=0 while fifo_empty=1.
//  2 FIFO preloaded with bits 1,0,1,1,0,0,1,0, out_ready=1 -> out_data=8'b0100_1101, out_valid for
//    exactly 1 cycle, exactly 8 pops, out_valid asserted 2 cycles after the 8th fifo_rd_en.
//  3 Same load, out_ready=0 for 5 cycles -> out_data/out_valid stable, fifo_rd_en=0 throughout HOLD.
//  4 fifo_empty toggled every 3 cycles while 16 bits 0xA5,0x3C arrive -> words 8'hA5 then 8'h3C,
//    no pop ever issued with fifo_empty=1.
//  5 reset_n pulsed low after 3 of 8 beats captured -> beat_count=0, next word built from fresh beats only.
//  6 FIFO_PACKER_PARITY_EN: words 8'hA5, 8'h07 -> out_parity 0 then 1; without macro port absent, build passes.

Source files
------------

// File: rtl/fifo_bit_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_bit_packer_pkg
// Description : Shared types and helpers for the FIFO bit packer:
//               the FILL/HOLD state encoding, a clog2 helper for sizing
//               counters, and default beat and word dimensions.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_bit_packer_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam int DEFAULT_DATA_WIDTH = 1;
  localparam int DEFAULT_WORD_BEATS = 8;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    return w;
  endfunction

  // A counter that must reach 'beats' inclusive needs clog2(beats+1) bits.
  function automatic int cnt_width(input int beats);
    int w;
    w = clog2(beats + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_shift_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_shift_packer
// Description : Slot-indexed register array. On load, one beat is written
//               into the slot selected by slot_i, and the other slots hold
//               their values. Clear zeroes the whole word.
//               When FIFO_PACKER_PARITY_EN is defined, an even-parity bit is
//               registered together with the word.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_shift_packer
  import fifo_bit_packer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int WORD_BEATS = DEFAULT_WORD_BEATS,
  parameter int IDX_W      = cnt_width(DEFAULT_WORD_BEATS)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic                             load_i,
  input  logic [IDX_W-1:0]                 slot_i,
  input  logic [DATA_WIDTH-1:0]            beat_i,
  output logic [DATA_WIDTH*WORD_BEATS-1:0] data_o
`ifdef FIFO_PACKER_PARITY_EN
  ,
  output logic                             parity_o
`endif
);

  localparam int OUT_W = DATA_WIDTH * WORD_BEATS;

  logic [OUT_W-1:0]      data_q;
  logic [OUT_W-1:0]      data_d;
  logic [WORD_BEATS-1:0] w_slot_hit;

  // Per-slot next value: clear wins, then a load aimed at this slot, else hold.
  generate
    for (genvar g = 0; g < WORD_BEATS; g++) begin : g_slot
      assign w_slot_hit[g] = load_i && (slot_i == IDX_W'(g));
      assign data_d[g*DATA_WIDTH +: DATA_WIDTH] =
        clear_i       ? {DATA_WIDTH{1'b0}} :
        w_slot_hit[g] ? beat_i             :
                        data_q[g*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Word register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

`ifdef FIFO_PACKER_PARITY_EN
  logic parity_q;

  // Parity is computed from the next word, so it changes in the same cycle as data_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^data_d;
    end
  end

  assign parity_o = parity_q;
`endif

endmodule
`default_nettype wire

// File: rtl/fifo_bit_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_bit_packer
// Description : Reads DATA_WIDTH-bit beats from the FIFO read port and packs
//               WORD_BEATS beats LSB-first into one word. The word is
//               presented on a valid/ready handshake.
//               Optional feature macro: FIFO_PACKER_PARITY_EN adds the
//               out_parity output (even parity of out_data).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_bit_packer
  import fifo_bit_packer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int WORD_BEATS = DEFAULT_WORD_BEATS,
  localparam int OUT_W     = DATA_WIDTH * WORD_BEATS,
  localparam int CNT_W     = cnt_width(WORD_BEATS)
) (
  input  logic                  rd_clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef FIFO_PACKER_PARITY_EN
  output logic                  out_parity,
`endif
  output logic [CNT_W-1:0]      beat_count
);

  localparam logic [CNT_W-1:0] c_beats = CNT_W'(WORD_BEATS);
  localparam logic [CNT_W-1:0] c_last  = CNT_W'(WORD_BEATS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] issued_q;
  logic [CNT_W-1:0] beat_count_q;
  logic             pending_q;
  logic             out_valid_q;

  logic             w_rd_en;
  logic             w_load;
  logic             w_accept;

  // A pop is issued only while filling, only if the FIFO has data, and at most
  // WORD_BEATS times per word. The issued counter prevents over-reading the FIFO.
  assign w_rd_en  = (state_q == ST_FILL) && !fifo_empty && (issued_q < c_beats);
  // A pop issued last cycle returns its data this cycle.
  assign w_load   = (state_q == ST_FILL) && pending_q;
  assign w_accept = (state_q == ST_HOLD) && out_valid_q && out_ready;

  // Control FSM: pop/capture bookkeeping while filling, and the handshake while holding.
  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_FILL;
      issued_q     <= '0;
      pending_q    <= 1'b0;
      beat_count_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      pending_q <= w_rd_en;
      if (w_rd_en) begin
        issued_q <= issued_q + 1'b1;
      end
      case (state_q)
        ST_FILL: begin
          if (pending_q) begin
            beat_count_q <= beat_count_q + 1'b1;
            if (beat_count_q == c_last) begin
              state_q     <= ST_HOLD;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (w_accept) begin
            state_q      <= ST_FILL;
            out_valid_q  <= 1'b0;
            beat_count_q <= '0;
            issued_q     <= '0;
          end
        end
        default: begin
          state_q <= ST_FILL;
        end
      endcase
    end
  end

  fifo_shift_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORD_BEATS (WORD_BEATS),
    .IDX_W      (CNT_W)
  ) u_shift_packer (
    .clk_i    (rd_clk),
    .rst_ni   (reset_n),
    .clear_i  (w_accept),
    .load_i   (w_load),
    .slot_i   (beat_count_q),
    .beat_i   (fifo_rd_data),
`ifdef FIFO_PACKER_PARITY_EN
    .parity_o (out_parity),
`endif
    .data_o   (out_data)
  );

  assign fifo_rd_en = w_rd_en;
  assign out_valid  = out_valid_q;
  assign beat_count = beat_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_bit_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_bit_packer
// Description : Directed testbench for fifo_bit_packer (DATA_WIDTH=1,
//               WORD_BEATS=8). It uses a behavioural FIFO with a 1-cycle read
//               latency. Parity checks are enabled with FIFO_PACKER_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_bit_packer;

  localparam int DW = 1;
  localparam int WB = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    beat_count;
`ifdef FIFO_PACKER_PARITY_EN
  logic          out_parity;
`endif

  always #5 clk = ~clk;

  fifo_bit_packer #(
    .DATA_WIDTH (DW),
    .WORD_BEATS (WB)
  ) dut (
    .rd_clk       (clk),
    .reset_n      (reset_n),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
`ifdef FIFO_PACKER_PARITY_EN
    .out_parity   (out_parity),
`endif
    .beat_count   (beat_count)
  );

  // Behavioural FIFO: data appears the cycle after a pop; reset drops contents.
  logic [DW-1:0] mem [0:1023];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          stall;

  assign fifo_empty = stall || (rd_ptr == wr_ptr);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Monitor: counts pops, illegal pops, valid cycles and accepted words.
  int         cyc          = 0;
  int         pop_total    = 0;
  int         bad_pops     = 0;
  int         valid_cycles = 0;
  int         last_pop_cyc = 0;
  int         rise_cyc     = 0;
  int         n_words      = 0;
  logic       prev_v       = 1'b0;
  logic [7:0] words   [0:31];
  logic       parities[0:31];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_v <= out_valid;
    if (fifo_rd_en) begin
      pop_total    <= pop_total + 1;
      last_pop_cyc <= cyc;
    end
    if (fifo_rd_en && fifo_empty) bad_pops <= bad_pops + 1;
    if (out_valid) valid_cycles <= valid_cycles + 1;
    if (out_valid === 1'b1 && !prev_v) rise_cyc <= cyc;
    if (out_valid === 1'b1 && out_ready === 1'b1 && n_words < 32) begin
      words[n_words] <= out_data;
`ifdef FIFO_PACKER_PARITY_EN
      parities[n_words] <= out_parity;
`else
      parities[n_words] <= ^out_data;
`endif
      n_words <= n_words + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < 8; i++) begin
      mem[wr_ptr] = v[i];
      wr_ptr++;
    end
  endtask

  task automatic drive_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input int target, input int limit, input string tag);
    int n;
    n = 0;
    while (n_words < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(tag, {31'd0, n_words >= target}, 32'd1);
  endtask

  int w0, p0, v0, b0, n;

  initial begin
    reset_n   = 1'b1;
    stall     = 1'b1;
    out_ready = 1'b0;

    // ---- Test 1: asynchronous reset ----
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_beat_count", {28'd0, beat_count}, 32'd0);
    check("rst_rd_en_empty", {31'd0, fifo_rd_en}, 32'd0);
`ifdef FIFO_PACKER_PARITY_EN
    check("rst_parity", {31'd0, out_parity}, 32'd0);
`endif

    // ---- Test 2: one word, out_ready high ----
    drive_step();
    w0 = n_words; p0 = pop_total; v0 = valid_cycles;
    push_byte(8'b0100_1101);
    out_ready = 1'b1;
    stall     = 1'b0;
    wait_words(w0 + 1, 40, "t2_timeout");
    repeat (3) @(negedge clk);
    check("t2_word", {24'd0, words[w0]}, 32'h4D);
    check("t2_valid_cycles", valid_cycles - v0, 32'd1);
    check("t2_pops", pop_total - p0, 32'd8);
    check("t2_latency", rise_cyc - last_pop_cyc, 32'd2);

    // ---- Test 3: back-pressure holds the word ----
    drive_step();
    out_ready = 1'b0;
    w0 = n_words;
    push_byte(8'b0100_1101);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t3_timeout", {31'd0, out_valid}, 32'd1);
    drive_step();
    push_byte(8'hFF);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t3_hold_data", {24'd0, out_data}, 32'h4D);
      check("t3_hold_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    end
    drive_step();
    out_ready = 1'b1;
    wait_words(w0 + 2, 40, "t3_timeout2");
    check("t3_word0", {24'd0, words[w0]}, 32'h4D);
    check("t3_word1", {24'd0, words[w0 + 1]}, 32'hFF);

    // ---- Test 4: FIFO empty flag toggles every 3 cycles ----
    drive_step();
    w0 = n_words; p0 = pop_total; b0 = bad_pops;
    push_byte(8'hA5);
    push_byte(8'h3C);
    for (int k = 0; k < 200 && n_words < w0 + 2; k++) begin
      stall = ((k / 3) % 2) == 0;
      drive_step();
    end
    stall = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_nwords", n_words - w0, 32'd2);
    check("t4_word0", {24'd0, words[w0]}, 32'hA5);
    check("t4_word1", {24'd0, words[w0 + 1]}, 32'h3C);
    check("t4_pops", pop_total - p0, 32'd16);
    check("t4_no_pop_when_empty", bad_pops - b0, 32'd0);
`ifdef FIFO_PACKER_PARITY_EN
    check("t4_parity_a5", {31'd0, parities[w0]}, 32'd0);
`endif

    // ---- Test 5: reset mid-word discards partial beats ----
    drive_step();
    for (int i = 0; i < 3; i++) begin
      mem[wr_ptr] = 1'b1;
      wr_ptr++;
    end
    n = 0;
    while (beat_count !== 4'd3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("t5_partial_count", {28'd0, beat_count}, 32'd3);
    check("t5_partial_valid", {31'd0, out_valid}, 32'd0);
    drive_step();
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_rst_count", {28'd0, beat_count}, 32'd0);
    check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    drive_step();
    reset_n = 1'b1;
    w0 = n_words;
    push_byte(8'h5A);
    wait_words(w0 + 1, 40, "t5_timeout");
    check("t5_fresh_word", {24'd0, words[w0]}, 32'h5A);

    // ---- Test 6: odd-parity word ----
    drive_step();
    w0 = n_words;
    push_byte(8'h07);
    wait_words(w0 + 1, 40, "t6_timeout");
    check("t6_word", {24'd0, words[w0]}, 32'h07);
`ifdef FIFO_PACKER_PARITY_EN
    check("t6_parity_07", {31'd0, parities[w0]}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
